// File: rtl/multicycle_control_unit.sv
// Multicycle control FSM: FETCH/DECODE/EXEC/MEM/WB plus I/O handshake wait and resumable halt.
// Define CTRL_ILLEGAL_TRAP_EN to trap undefined opcodes into HALT (sets sticky 'illegal').
module multicycle_control_unit #(
    parameter int unsigned ALUOP_W    = 3,
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned IO_TIMEOUT = 0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [5:0]         Opcode,
    input  logic               in_valid,
    input  logic               out_ready,
    input  logic               resume,
    output logic               ir_write,
    output logic               pc_write,
    output logic [1:0]         RegisterDST,
    output logic [1:0]         Jump,
    output logic [1:0]         memtoReg,
    output logic               Branch,
    output logic               ALUSrc,
    output logic               regWrite,
    output logic               memWrite,
    output logic               Save,
    output logic               Load,
    output logic               input_flag,
    output logic               output_flag,
    output logic               halt,
    output logic [ALUOP_W-1:0] Alu_op,
    output logic [2:0]         state,
    output logic [CNT_W-1:0]   retired,
    output logic               io_timeout,
    output logic               illegal
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        IOWAIT = 3'd5,
        HALT   = 3'd6
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b000001;
    localparam logic [5:0] OP_SW   = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b000011;
    localparam logic [5:0] OP_SUBI = 6'b000100;
    localparam logic [5:0] OP_BEQ  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b001001;
    localparam logic [5:0] OP_JR   = 6'b001010;
    localparam logic [5:0] OP_JAL  = 6'b001011;
    localparam logic [5:0] OP_IN   = 6'b001100;
    localparam logic [5:0] OP_OUT  = 6'b001101;
    localparam logic [5:0] OP_SAVE = 6'b001110;
    localparam logic [5:0] OP_LOAD = 6'b001111;
    localparam logic [5:0] OP_HALT = 6'b111111;

    // Counter only needs to reach IO_TIMEOUT-1: the cycle it holds that value is the last wait cycle.
    localparam int unsigned WCNT_W = (IO_TIMEOUT > 1) ? $clog2(IO_TIMEOUT) : 1;

    state_t            state_q;
    logic [5:0]        op_q;
    logic [CNT_W-1:0]  retired_q;
    logic [WCNT_W-1:0] wcnt_q;
    logic              timeout_q;
    logic              handshake;
    logic              timeout_hit;

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic illegal_q;

    function automatic logic op_defined(input logic [5:0] op);
        case (op)
            OP_R, OP_LW, OP_SW, OP_ADDI, OP_SUBI, OP_BEQ, OP_J, OP_JR, OP_JAL,
            OP_IN, OP_OUT, OP_SAVE, OP_LOAD, OP_HALT: return 1'b1;
            default:                                  return 1'b0;
        endcase
    endfunction

    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

    assign handshake   = (op_q == OP_IN) ? in_valid : out_ready;
    assign timeout_hit = (IO_TIMEOUT != 0) && (wcnt_q == WCNT_W'(IO_TIMEOUT - 1));
    assign state       = state_q;
    assign retired     = retired_q;
    assign io_timeout  = timeout_q;

    always_comb begin
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        RegisterDST = 2'b00;
        Jump        = 2'b00;
        memtoReg    = 2'b00;
        Branch      = 1'b0;
        ALUSrc      = 1'b0;
        regWrite    = 1'b0;
        memWrite    = 1'b0;
        Save        = 1'b0;
        Load        = 1'b0;
        input_flag  = 1'b0;
        output_flag = 1'b0;
        halt        = 1'b0;
        Alu_op      = '0;

        if (state_q inside {EXEC, MEM, WB, IOWAIT}) begin
            case (op_q)
                OP_R:    begin RegisterDST = 2'b01; Alu_op = ALUOP_W'(3'b100); end
                OP_LW:   begin ALUSrc = 1'b1; memtoReg = 2'b01; end
                OP_SW:   ALUSrc = 1'b1;
                OP_ADDI: begin ALUSrc = 1'b1; Alu_op = ALUOP_W'(3'b000); end
                OP_SUBI: begin ALUSrc = 1'b1; Alu_op = ALUOP_W'(3'b001); end
                OP_BEQ:  begin Branch = 1'b1; Alu_op = ALUOP_W'(3'b011); end
                OP_J:    Jump = 2'b01;
                OP_JR:   begin Jump = 2'b10; RegisterDST = 2'b10; end
                OP_JAL:  begin Jump = 2'b01; RegisterDST = 2'b10; memtoReg = 2'b10; end
                OP_IN:   begin RegisterDST = 2'b11; memtoReg = 2'b11; end
                OP_SAVE: Save = 1'b1;
                OP_LOAD: Load = 1'b1;
                default: ;
            endcase
        end

        case (state_q)
            FETCH: ir_write = 1'b1;
            EXEC: begin
                if (!(op_q inside {OP_R, OP_ADDI, OP_SUBI, OP_JAL, OP_LW, OP_SW, OP_SAVE, OP_LOAD}))
                    pc_write = 1'b1;
            end
            MEM: begin
                if (op_q inside {OP_SW, OP_SAVE}) begin
                    memWrite = 1'b1;
                    pc_write = 1'b1;
                end
            end
            WB: begin
                regWrite = 1'b1;
                pc_write = 1'b1;
            end
            IOWAIT: begin
                input_flag  = (op_q == OP_IN);
                output_flag = (op_q != OP_IN);
                if (handshake) begin
                    pc_write = 1'b1;
                    regWrite = (op_q == OP_IN);
                end else if (timeout_hit) begin
                    pc_write = 1'b1;
                end
            end
            HALT: begin
                halt     = 1'b1;
                pc_write = resume;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= FETCH;
            op_q      <= '0;
            retired_q <= '0;
            wcnt_q    <= '0;
            timeout_q <= 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            if (pc_write)
                retired_q <= retired_q + CNT_W'(1);

            case (state_q)
                FETCH: state_q <= DECODE;
                DECODE: begin
                    op_q <= Opcode;
                    if (Opcode == OP_HALT)
                        state_q <= HALT;
                    else if (Opcode == OP_IN || Opcode == OP_OUT)
                        state_q <= IOWAIT;
`ifdef CTRL_ILLEGAL_TRAP_EN
                    else if (!op_defined(Opcode)) begin
                        illegal_q <= 1'b1;
                        state_q   <= HALT;
                    end
`endif
                    else
                        state_q <= EXEC;
                end
                EXEC: begin
                    if (op_q inside {OP_R, OP_ADDI, OP_SUBI, OP_JAL})
                        state_q <= WB;
                    else if (op_q inside {OP_LW, OP_SW, OP_SAVE, OP_LOAD})
                        state_q <= MEM;
                    else
                        state_q <= FETCH;
                end
                MEM:   state_q <= (op_q inside {OP_LW, OP_LOAD}) ? WB : FETCH;
                WB:    state_q <= FETCH;
                IOWAIT: begin
                    // A handshake in the timeout cycle completes normally and leaves io_timeout clear.
                    if (handshake) begin
                        state_q <= FETCH;
                        wcnt_q  <= '0;
                    end else if (timeout_hit) begin
                        state_q   <= FETCH;
                        wcnt_q    <= '0;
                        timeout_q <= 1'b1;
                    end else if (IO_TIMEOUT != 0) begin
                        wcnt_q <= wcnt_q + WCNT_W'(1);
                    end
                end
                HALT: begin
                    if (resume)
                        state_q <= FETCH;
                end
                default: state_q <= FETCH;
            endcase
        end
    end

endmodule
